msrv32_lsu: RTL and testbench

MSRV32_LSU -- requirements
Module: msrv32_lsu

---
 rtl/msrv32_lsu.sv | 80 ++++++++
 tb/tb_msrv32_lsu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/msrv32_lsu.sv
// msrv32_lsu: RV32I load/store unit with single-outstanding memory access, misalignment and timeout faults
module msrv32_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic        is_store_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_mask_out,
    input  logic        dmem_ack_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [31:0] load_data_out,
    output logic        misaligned_out,
    output logic        fault_out
);
    localparam int CW = $clog2(TIMEOUT) > 0 ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t state, next;
    logic          is_store;
    logic [2:0]    funct3;
    logic [31:0]   addr, rs2, sh, ext;
    logic [CW-1:0] cnt;
    logic          mis_start, tmo;
    always_comb begin
        mis_start = funct3_in == 3'b011 || funct3_in[2:1] == 2'b11 ||
                    (funct3_in[1:0] == 2'b01 && iadder_in[0]) ||
                    (funct3_in[1:0] == 2'b10 && iadder_in[1:0] != 2'b00);
        tmo = state == REQ && !dmem_ack_in && cnt == CW'(TIMEOUT - 1);
        next = state == IDLE ? (start_in && !mis_start ? REQ : IDLE) :
               state == REQ  ? (dmem_ack_in || tmo ? RESP : REQ) : IDLE;
        sh = dmem_rdata_in >> {addr[1:0], 3'b000};
        ext = funct3[1:0] == 2'b00 ? {{24{!funct3[2] && sh[7]}}, sh[7:0]} :
              funct3[1:0] == 2'b01 ? {{16{!funct3[2] && sh[15]}}, sh[15:0]} : sh;
    end
    assign dmem_req_out   = state == REQ;
    assign busy_out       = state == REQ;
    assign dmem_we_out    = state == REQ && is_store;
    assign dmem_addr_out  = {addr[31:2], 2'b00};
    assign dmem_mask_out  = !is_store ? 4'b0000 :
                            funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                            funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign dmem_wdata_out = funct3[1:0] == 2'b00 ? {4{rs2[7:0]}} :
                            funct3[1:0] == 2'b01 ? {2{rs2[15:0]}} : rs2;
    assign done_out       = state == RESP || misaligned_out;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            is_store       <= 1'b0;
            funct3         <= 3'b000;
            addr           <= 32'h0;
            rs2            <= 32'h0;
            cnt            <= '0;
            load_data_out  <= 32'h0;
            misaligned_out <= 1'b0;
            fault_out      <= 1'b0;
        end else begin
            state          <= next;
            misaligned_out <= state == IDLE && start_in && mis_start;
            fault_out      <= tmo;
            cnt            <= state == REQ ? cnt + CW'(1) : '0;
            if (state == IDLE && start_in) begin
                is_store <= is_store_in;
                funct3   <= funct3_in;
                addr     <= iadder_in;
                rs2      <= rs2_in;
            end
            if (state == REQ && dmem_ack_in && !is_store)
                load_data_out <= ext;
        end
    end
endmodule

// File: tb/tb_msrv32_lsu.sv
// tb_msrv32_lsu: directed scoreboard bench for msrv32_lsu
module tb_msrv32_lsu;
    logic        clk_in = 0, rst_n_in = 0, start_in = 0, is_store_in = 0;
    logic [2:0]  funct3_in = 0;
    logic [31:0] iadder_in = 0, rs2_in = 0, dmem_rdata_in = 0;
    logic        dmem_ack_in = 0;
    logic        dmem_req_out, dmem_we_out, busy_out, done_out, misaligned_out, fault_out;
    logic [31:0] dmem_addr_out, dmem_wdata_out, load_data_out;
    logic [3:0]  dmem_mask_out;

    msrv32_lsu #(.TIMEOUT(16)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .is_store_in(is_store_in),
        .funct3_in(funct3_in), .iadder_in(iadder_in), .rs2_in(rs2_in),
        .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out), .dmem_addr_out(dmem_addr_out),
        .dmem_wdata_out(dmem_wdata_out), .dmem_mask_out(dmem_mask_out), .dmem_ack_in(dmem_ack_in),
        .dmem_rdata_in(dmem_rdata_in), .busy_out(busy_out), .done_out(done_out),
        .load_data_out(load_data_out), .misaligned_out(misaligned_out), .fault_out(fault_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc++;

    // memory responder: ack after ack_lat REQ cycles (-1 = never)
    int ack_lat = 0, rc = 0;
    always @(negedge clk_in) begin
        if (dmem_req_out) begin
            dmem_ack_in = (rc == ack_lat);
            rc++;
        end else begin
            dmem_ack_in = 0;
            rc = 0;
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        fault;
        logic        mis;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int errors = 0, checks = 0, t0 = 0;
    logic [31:0] last_load = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_in);
        start_in = 1; is_store_in = st; funct3_in = f3; iadder_in = a; rs2_in = d;
        t0 = cyc;
        @(negedge clk_in);
        start_in = 0; is_store_in = 0; funct3_in = 0; iadder_in = 32'hFFFF_FFFF; rs2_in = 0;
    endtask

    task automatic push(input logic [31:0] d, input logic f, input logic m, input int l);
        exp_t e;
        e.data = d; e.fault = f; e.mis = m; e.lat = l;
        sb.push_back(e);
        if (!f && !m) last_load = d;
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        for (int i = 0; i < 40 && !done_out; i++) @(negedge clk_in);
        e = sb.pop_front();
        check({tag, "_done"}, 32'(done_out), 32'd1);
        check({tag, "_data"}, load_data_out, e.data);
        check({tag, "_fault"}, 32'(fault_out), 32'(e.fault));
        check({tag, "_mis"}, 32'(misaligned_out), 32'(e.mis));
        check({tag, "_lat"}, 32'(cyc - t0), 32'(e.lat));
        check({tag, "_busy"}, 32'(busy_out), 32'd0);
        @(negedge clk_in);
        check({tag, "_done_pulse"}, 32'(done_out), 32'd0);
    endtask

    task automatic check_req(input string tag, input logic we, input logic [31:0] a,
                             input logic [3:0] m, input logic [31:0] wd);
        check({tag, "_req"}, 32'(dmem_req_out), 32'd1);
        check({tag, "_we"}, 32'(dmem_we_out), 32'(we));
        check({tag, "_addr"}, dmem_addr_out, a);
        check({tag, "_mask"}, 32'(dmem_mask_out), 32'(m));
        check({tag, "_wdata"}, dmem_wdata_out, wd);
    endtask

    initial begin
        logic saw;
        #2;
        check("rst_req", 32'(dmem_req_out), 0);
        check("rst_outs", {dmem_we_out, busy_out, done_out, misaligned_out, fault_out, dmem_mask_out}, 0);
        check("rst_addr", dmem_addr_out, 0);
        check("rst_wdata", dmem_wdata_out, 0);
        check("rst_load", load_data_out, 0);
        @(negedge clk_in);
        rst_n_in = 1;

        // LW zero-wait
        ack_lat = 0; dmem_rdata_in = 32'hDEADBEEF;
        issue(0, 3'b010, 32'h1000, 0);
        push(32'hDEADBEEF, 0, 0, 2);
        check_req("lw", 0, 32'h1000, 4'b0000, 32'h0);
        wait_done("lw");

        // LB / LBU sign/zero extension, byte lane 3
        dmem_rdata_in = 32'h80123456;
        issue(0, 3'b000, 32'h2003, 0);
        push(32'hFFFFFF80, 0, 0, 2);
        wait_done("lb");
        issue(0, 3'b100, 32'h2003, 0);
        push(32'h00000080, 0, 0, 2);
        wait_done("lbu");

        // LH / LHU upper half
        dmem_rdata_in = 32'h9ABC0000;
        issue(0, 3'b001, 32'h2102, 0);
        push(32'hFFFF9ABC, 0, 0, 2);
        wait_done("lh");
        issue(0, 3'b101, 32'h2102, 0);
        push(32'h00009ABC, 0, 0, 2);
        wait_done("lhu");

        // SH with 2 wait cycles, stray start in REQ ignored, outputs held
        ack_lat = 2;
        issue(1, 3'b001, 32'h3002, 32'h1234ABCD);
        push(last_load, 0, 0, 4);
        check_req("sh1", 1, 32'h3000, 4'b1100, 32'hABCDABCD);
        start_in = 1; funct3_in = 3'b010; iadder_in = 32'h9000;
        @(negedge clk_in);
        start_in = 0;
        check_req("sh2", 1, 32'h3000, 4'b1100, 32'hABCDABCD);
        wait_done("sh");
        check("sh_idle", 32'(busy_out), 0);

        // SB lane 1
        ack_lat = 0;
        issue(1, 3'b000, 32'h7001, 32'h000000AB);
        push(last_load, 0, 0, 2);
        check_req("sb", 1, 32'h7000, 4'b0010, 32'hABABABAB);
        wait_done("sb");

        // misaligned LW and unlisted funct3
        issue(0, 3'b010, 32'h4001, 0);
        push(last_load, 0, 1, 1);
        check("mis_req", 32'(dmem_req_out), 0);
        wait_done("mis_lw");
        issue(0, 3'b011, 32'h4000, 0);
        push(last_load, 0, 1, 1);
        wait_done("mis_f3");

        // timeout, then ack on the terminal cycle wins
        ack_lat = -1;
        issue(0, 3'b010, 32'h5000, 0);
        push(last_load, 1, 0, 17);
        wait_done("tmo");
        ack_lat = 15; dmem_rdata_in = 32'hCAFEF00D;
        issue(0, 3'b010, 32'h5004, 0);
        push(32'hCAFEF00D, 0, 0, 17);
        wait_done("ack_term");

        // reset during REQ
        ack_lat = -1;
        issue(0, 3'b010, 32'h5008, 0);
        check("rreq_before", 32'(dmem_req_out), 1);
        #2 rst_n_in = 0;
        #1;
        check("rreq_drop", 32'(dmem_req_out), 0);
        check("rreq_busy", 32'(busy_out), 0);
        check("rreq_load", load_data_out, 0);
        saw = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            saw |= done_out;
        end
        check("rreq_nodone", 32'(saw), 0);
        @(posedge clk_in);
        #2 rst_n_in = 1;
        last_load = 0;
        ack_lat = 0; dmem_rdata_in = 32'h13579BDF;
        issue(0, 3'b010, 32'h6000, 0);
        push(32'h13579BDF, 0, 0, 2);
        wait_done("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
